alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 16-bit ALU between two requesters, e.g. the instruction datapath (port 0) and the address/loop unit (port 1). It accepts one operation at a time over a req/ack handshake and registers the operands onto the ALU inputs. After a fixed settle cycle it captures the ALU result and zero flag and returns them to the granted requester. It also parks the ALU between operations and stops granting once the ALU raises its finish output.

## Interface
- DATA_LEN, 16, operand/result width
- ALU_SIG_LEN, 3, ALU select width
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- req0 / req1  input  1  operation request, held high until the matching rsp_valid
- op0 / op1  input  ALU_SIG_LEN  ALU select code for the request
- a0, b0 / a1, b1  input  DATA_LEN  operands
- alu_out  input  DATA_LEN  ALU result
- alu_z  input  1  ALU zero flag
- alu_finish  input  1  ALU finish output
- alu_a, alu_b  output  DATA_LEN  registered ALU operands
- alu_sel  output  ALU_SIG_LEN  registered ALU select
- gnt0 / gnt1  output  1  requester owns the ALU
- rsp_valid0 / rsp_valid1  output  1  one-cycle ack with the result
- rsp_data  output  DATA_LEN  captured result, shared by both ports
- rsp_z  output  1  captured zero flag
- busy  output  1  state is not IDLE
- halted  output  1  finish seen; no further grants

## Operation
- FSM states: IDLE → DRIVE → SETTLE → DONE → IDLE.
- IDLE:
  - alu_sel = 3'b101 (park code, clear).
  - If any req is high and halted = 0, select a winner and register its op/a/b onto alu_sel/alu_a/alu_b.
  - Set that port's gnt, then go to DRIVE.
- Park purpose: the ALU re-evaluates only on an A or select change. Parking guarantees a select transition on every issue, even for back-to-back identical ops.
- DRIVE: ALU inputs held; go to SETTLE.
- SETTLE:
  - Capture alu_out → rsp_data and alu_z → rsp_z.
  - Pulse the winner's rsp_valid, clear gnt, set alu_sel = 3'b101, go to DONE.
- DONE:
  - rsp_valid high for this cycle only.
  - Requests are ignored, so a requester that deasserts on the next edge is not re-granted.
  - Go to IDLE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: see Configuration.
- last_grant updates on every grant.
- rsp_z is passed through unmodified. It is meaningful only for add (000) and sub (001); for other ops it is the ALU's previous flag value.
- halted:
  - Set on the edge after alu_finish is sampled high; sticky until reset.
  - An operation already in flight completes normally.
  - Op 3'b110 is forwarded like any other op.
- A req that drops before rsp_valid is a protocol error. The operation still completes and rsp_valid still pulses.

## Timing
- Reset values: state IDLE; alu_sel 3'b101; alu_a, alu_b, rsp_data 0; gnt*, rsp_valid*, rsp_z, busy, halted 0; last_grant = 1 (port 0 favoured first).
- Request sampled at edge E0 → alu_* valid after E0 → result captured at E2 → rsp_valid high during cycle E2..E3.
- Latency: 2 cycles from the grant edge to rsp_valid.
- Throughput: one operation per 4 cycles.
- gnt is high from after E0 until E2.
- busy is high in DRIVE, SETTLE and DONE.
- Reset mid-operation: return to IDLE next edge, no rsp_valid, all outputs to reset values.
- req and reset high on the same edge: reset wins.

## Configuration
- ALU_ARB_RR_EN defined: round robin. When both request in IDLE, grant the port that was not last_grant.
- ALU_ARB_RR_EN undefined: fixed priority. Port 0 always wins a simultaneous request; last_grant is still maintained but unused.

## Test plan
- Single add: req0, op0=000, a0=5, b0=7 → alu_sel 000 after E0; rsp_valid0 at E2 with rsp_data=12, rsp_z=0; gnt1 never set.
- Zero flag: req1, op1=001, a1=9, b1=9 → rsp_valid1 with rsp_data=0, rsp_z=1.
- Contention with both held for 3 operations:
  - RR defined: grants 0,1,0.
  - RR undefined: grants 0,0,0.
  - alu_sel returns to 101 between issues.
- Back-to-back identical op: two successive req0 mult, a0=3, b0=4 → both responses return 12, and the 101 park cycle is observed between them.
- Halt: req0 op0=110, then alu_finish driven high → halted=1; a later req1 gets no gnt1. Reset clears halted and req1 is then served.
- Reset at SETTLE → no rsp_valid, alu_sel=101, busy=0 on the next cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared 16-bit ALU: registers one request's operands onto the ALU,
// waits a settle cycle, and returns the captured result. Define ALU_ARB_RR_EN for round-robin arbitration.
module alu_arbiter #(
  parameter int DATA_LEN    = 16,
  parameter int ALU_SIG_LEN = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [ALU_SIG_LEN-1:0] op0,
  input  logic [ALU_SIG_LEN-1:0] op1,
  input  logic [DATA_LEN-1:0]    a0,
  input  logic [DATA_LEN-1:0]    b0,
  input  logic [DATA_LEN-1:0]    a1,
  input  logic [DATA_LEN-1:0]    b1,
  input  logic [DATA_LEN-1:0]    alu_out,
  input  logic                   alu_z,
  input  logic                   alu_finish,
  output logic [DATA_LEN-1:0]    alu_a,
  output logic [DATA_LEN-1:0]    alu_b,
  output logic [ALU_SIG_LEN-1:0] alu_sel,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rsp_valid0,
  output logic                   rsp_valid1,
  output logic [DATA_LEN-1:0]    rsp_data,
  output logic                   rsp_z,
  output logic                   busy,
  output logic                   halted
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_DONE} state_t;

  // Parking the select guarantees the ALU sees a select edge on every issue.
  localparam logic [ALU_SIG_LEN-1:0] PARK_SEL = ALU_SIG_LEN'(3'b101);

  state_t                   r_state, w_state_nxt;
  logic [DATA_LEN-1:0]      r_alu_a, w_alu_a_nxt;
  logic [DATA_LEN-1:0]      r_alu_b, w_alu_b_nxt;
  logic [ALU_SIG_LEN-1:0]   r_alu_sel, w_alu_sel_nxt;
  logic [1:0]               r_gnt, w_gnt_nxt;
  logic [1:0]               r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_LEN-1:0]      r_rsp_data, w_rsp_data_nxt;
  logic                     r_rsp_z, w_rsp_z_nxt;
  logic                     r_last_grant, w_last_grant_nxt;
  logic                     r_halted, w_halted_nxt;
  logic                     w_any_req;
  logic                     w_win;

  assign w_any_req = req0 | req1;

`ifdef ALU_ARB_RR_EN
  assign w_win = (req0 && req1) ? ~r_last_grant : req1;
`else
  assign w_win = ~req0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_nxt      = r_state;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_sel_nxt    = r_alu_sel;
    w_gnt_nxt        = r_gnt;
    w_rsp_valid_nxt  = 2'b00;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_z_nxt      = r_rsp_z;
    w_last_grant_nxt = r_last_grant;
    w_halted_nxt     = r_halted | alu_finish;

    case (r_state)
      ST_IDLE: begin
        w_alu_sel_nxt = PARK_SEL;
        if (w_any_req && !r_halted) begin
          w_alu_sel_nxt    = w_win ? op1 : op0;
          w_alu_a_nxt      = w_win ? a1  : a0;
          w_alu_b_nxt      = w_win ? b1  : b0;
          w_gnt_nxt        = w_win ? 2'b10 : 2'b01;
          w_last_grant_nxt = w_win;
          w_state_nxt      = ST_DRIVE;
        end
      end
      ST_DRIVE: w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        w_rsp_data_nxt  = alu_out;
        w_rsp_z_nxt     = alu_z;
        w_rsp_valid_nxt = r_gnt;
        w_gnt_nxt       = 2'b00;
        w_alu_sel_nxt   = PARK_SEL;
        w_state_nxt     = ST_DONE;
      end
      // Requests are deliberately ignored here so a requester dropping on this edge is not re-granted.
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= PARK_SEL;
      r_gnt        <= 2'b00;
      r_rsp_valid  <= 2'b00;
      r_rsp_data   <= '0;
      r_rsp_z      <= 1'b0;
      r_last_grant <= 1'b1;
      r_halted     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_sel    <= w_alu_sel_nxt;
      r_gnt        <= w_gnt_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_z      <= w_rsp_z_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_halted     <= w_halted_nxt;
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign gnt0       = r_gnt[0];
  assign gnt1       = r_gnt[1];
  assign rsp_valid0 = r_rsp_valid[0];
  assign rsp_valid1 = r_rsp_valid[1];
  assign rsp_data   = r_rsp_data;
  assign rsp_z      = r_rsp_z;
  assign busy       = (r_state != ST_IDLE);
  assign halted     = r_halted;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU plus a reference model that predicts winner,
// result and zero flag; a negedge monitor pops and compares every response.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic [15:0] alu_out = '0;
  logic        alu_z = 1'b0;
  logic        alu_finish;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [15:0] rsp_data;
  logic        rsp_z, busy, halted;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .alu_out(alu_out), .alu_z(alu_z), .alu_finish(alu_finish),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, sub, and, or, mult, park(clear), finish(pass a), xor.
  function automatic logic [15:0] alu_fn(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a * b;
      3'd5:    return 16'h0000;
      3'd6:    return a;
      default: return a ^ b;
    endcase
  endfunction

  always @(alu_a or alu_b or alu_sel) begin
    alu_out = alu_fn(alu_sel, alu_a, alu_b);
    if (alu_sel == 3'd0 || alu_sel == 3'd1) alu_z = (alu_out == 16'h0000);
  end

  typedef struct {
    bit          port;
    logic [15:0] data;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: who was granted last, and the ALU's sticky zero flag.
  bit   ref_last = 1'b1;
  logic ref_z    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pick_winner(input bit r0, input bit r1, input bit last);
    if (r0 && r1) begin
`ifdef ALU_ARB_RR_EN
      return !last;
`else
      return 1'b0;
`endif
    end
    return r1;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid0 || rsp_valid1) begin
      check("rsp_onehot", {31'd0, rsp_valid0 & rsp_valid1}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_port", {31'd0, rsp_valid1}, {31'd0, mon_e.port});
        check("rsp_data", {16'd0, rsp_data}, {16'd0, mon_e.data});
        check("rsp_z", {31'd0, rsp_z}, {31'd0, mon_e.z});
      end
    end
  end

  // Holds the given requests for n operations, predicting each winner and response.
  task automatic run_ops(input bit r0, input bit r1, input int n,
                         input logic [2:0] o0, input logic [15:0] x0, input logic [15:0] y0,
                         input logic [2:0] o1, input logic [15:0] x1, input logic [15:0] y1);
    bit   wins[$];
    exp_t e;
    bit   w;
    bit   seen;
    int   lat;
    logic [15:0] res;
    for (int i = 0; i < n; i++) begin
      w = pick_winner(r0, r1, ref_last);
      ref_last = w;
      res = w ? alu_fn(o1, x1, y1) : alu_fn(o0, x0, y0);
      if ((w ? o1 : o0) <= 3'd1) ref_z = (res == 16'h0000);
      e.port = w; e.data = res; e.z = ref_z;
      sb_q.push_back(e);
      wins.push_back(w);
    end
    @(negedge clk);
    req0 = r0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; op1 = o1; a1 = x1; b1 = y1;
    for (int i = 0; i < n; i++) begin
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (gnt0 || gnt1) begin seen = 1'b1; break; end
      end
      check("grant_seen", {31'd0, seen}, 32'd1);
      if (!seen) begin req0 = 1'b0; req1 = 1'b0; sb_q.delete(); return; end
      check("gnt0", {31'd0, gnt0}, {31'd0, !wins[i]});
      check("gnt1", {31'd0, gnt1}, {31'd0, wins[i]});
      check("alu_sel_issue", {29'd0, alu_sel}, {29'd0, wins[i] ? o1 : o0});
      check("alu_a_issue", {16'd0, alu_a}, {16'd0, wins[i] ? x1 : x0});
      check("alu_b_issue", {16'd0, alu_b}, {16'd0, wins[i] ? y1 : y0});
      check("busy_active", {31'd0, busy}, 32'd1);
      lat = 0; seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        lat++;
        if (rsp_valid0 || rsp_valid1) begin seen = 1'b1; break; end
      end
      check("rsp_latency", lat, 32'd2);
      if (!seen) begin req0 = 1'b0; req1 = 1'b0; sb_q.delete(); return; end
      check("park_sel", {29'd0, alu_sel}, 32'd5);
      check("gnt_cleared", {30'd0, gnt1, gnt0}, 32'd0);
      if (i == n - 1) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount;
    logic [2:0]  ops[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [2:0]  ro0, ro1;
    logic [15:0] ra0, rb0, ra1, rb1;
    bit          rr0, rr1;
    bit          seen;

    reset = 1'b1; alu_finish = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_alu_sel", {29'd0, alu_sel}, 32'd5);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_flags", {25'd0, gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_z, busy, halted}, 32'd0);

    // Single add, then a sub that yields zero.
    run_ops(1, 0, 1, 3'd0, 16'd5, 16'd7, 3'd0, 16'd0, 16'd0);
    run_ops(0, 1, 1, 3'd0, 16'd0, 16'd0, 3'd1, 16'd9, 16'd9);
    // Contention for three operations.
    run_ops(1, 1, 3, 3'd0, 16'd100, 16'd23, 3'd7, 16'h00ff, 16'h0f0f);
    // Back-to-back identical multiplies.
    run_ops(1, 0, 2, 3'd4, 16'd3, 16'd4, 3'd0, 16'd0, 16'd0);

    for (int r = 0; r < 12; r++) begin
      rr0 = 1'($urandom_range(0, 1));
      rr1 = rr0 ? 1'($urandom_range(0, 1)) : 1'b1;
      ro0 = ops[$urandom_range(0, 5)];
      ro1 = ops[$urandom_range(0, 5)];
      ra0 = 16'($urandom); ra1 = 16'($urandom);
      rb0 = ($urandom_range(0, 1) == 1) ? ra0 : 16'($urandom);
      rb1 = ($urandom_range(0, 1) == 1) ? ra1 : 16'($urandom);
      run_ops(rr0, rr1, $urandom_range(1, 3), ro0, ra0, rb0, ro1, ra1, rb1);
    end

    // Reset while the operation sits in SETTLE.
    @(negedge clk);
    req0 = 1'b1; op0 = 3'd2; a0 = 16'h1234; b0 = 16'h00ff;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt0) begin seen = 1'b1; break; end
    end
    check("midrst_grant", {31'd0, seen}, 32'd1);
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("midrst_no_rsp", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    check("midrst_alu_sel", {29'd0, alu_sel}, 32'd5);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    reset = 1'b0;
    ref_last = 1'b1;

    // Finish op, then halt: a later request must not be granted.
    run_ops(1, 0, 1, 3'd6, 16'hbeef, 16'd1, 3'd0, 16'd0, 16'd0);
    check("pre_halt", {31'd0, halted}, 32'd0);
    @(negedge clk);
    alu_finish = 1'b1;
    @(negedge clk);
    alu_finish = 1'b0;
    check("halted_set", {31'd0, halted}, 32'd1);
    req1 = 1'b1; op1 = 3'd0; a1 = 16'd1; b1 = 16'd2;
    gcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt1 || busy) gcount++;
    end
    check("halted_no_grant", gcount, 32'd0);
    check("halted_sticky", {31'd0, halted}, 32'd1);
    req1 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_last = 1'b1;
    check("halted_cleared", {31'd0, halted}, 32'd0);
    run_ops(0, 1, 1, 3'd0, 16'd0, 16'd0, 3'd0, 16'd40, 16'd2);

    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
